// File: rtl/alu_unit.sv
// alu_unit: single-cycle integer ALU feeding a 2-entry result buffer.
// Results are handed to the ROB through a valid/ready head interface.
module alu_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        is_empty_from_rs,
    input  logic [5:0]  op_from_rs,
    input  logic [31:0] v1_from_rs,
    input  logic [31:0] v2_from_rs,
    input  logic [31:0] imm_from_rs,
    input  logic [31:0] pc_from_rs,
    input  logic        is_exception_from_rob,
    input  logic        is_ready_from_rob,
    output logic        is_valid_to_rob,
    output logic [31:0] pc_to_rob,
    output logic [31:0] data_to_rob,
    output logic [31:0] target_pc_to_rob,
    output logic        is_jump_to_rob,
    output logic        is_stall_to_rs,
    output logic        overflow_err
);

    localparam logic [5:0] OP_LUI   = 6'd1;
    localparam logic [5:0] OP_AUIPC = 6'd2;
    localparam logic [5:0] OP_JAL   = 6'd3;
    localparam logic [5:0] OP_JALR  = 6'd4;
    localparam logic [5:0] OP_BEQ   = 6'd5;
    localparam logic [5:0] OP_BNE   = 6'd6;
    localparam logic [5:0] OP_BLT   = 6'd7;
    localparam logic [5:0] OP_BGE   = 6'd8;
    localparam logic [5:0] OP_BLTU  = 6'd9;
    localparam logic [5:0] OP_BGEU  = 6'd10;
    localparam logic [5:0] OP_ADDI  = 6'd11;
    localparam logic [5:0] OP_SLTI  = 6'd12;
    localparam logic [5:0] OP_SLTIU = 6'd13;
    localparam logic [5:0] OP_XORI  = 6'd14;
    localparam logic [5:0] OP_ORI   = 6'd15;
    localparam logic [5:0] OP_ANDI  = 6'd16;
    localparam logic [5:0] OP_SLLI  = 6'd17;
    localparam logic [5:0] OP_SRLI  = 6'd18;
    localparam logic [5:0] OP_SRAI  = 6'd19;
    localparam logic [5:0] OP_ADD   = 6'd20;
    localparam logic [5:0] OP_SUB   = 6'd21;
    localparam logic [5:0] OP_SLL   = 6'd22;
    localparam logic [5:0] OP_SLT   = 6'd23;
    localparam logic [5:0] OP_SLTU  = 6'd24;
    localparam logic [5:0] OP_XOR   = 6'd25;
    localparam logic [5:0] OP_SRL   = 6'd26;
    localparam logic [5:0] OP_SRA   = 6'd27;
    localparam logic [5:0] OP_OR    = 6'd28;
    localparam logic [5:0] OP_AND   = 6'd29;

    logic [31:0] pc_q   [2];
    logic [31:0] pc_d   [2];
    logic [31:0] data_q [2];
    logic [31:0] data_d [2];
    logic [31:0] tgt_q  [2];
    logic [31:0] tgt_d  [2];
    logic [1:0]  jmp_q;
    logic [1:0]  jmp_d;
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        head_q;
    logic        head_d;
    logic        tail_q;
    logic        tail_d;
    logic        ovf_q;
    logic        ovf_d;

    logic [31:0] op2;
    logic [4:0]  shamt;
    logic [31:0] pc_plus4;
    logic [31:0] pc_plus_imm;
    logic [31:0] jalr_sum;
    logic        is_itype;
    logic        eq;
    logic        lt_s;
    logic        lt_u;
    logic        taken;
    logic [31:0] res_data;
    logic [31:0] res_tgt;
    logic        res_jmp;
    logic        push;
    logic        pop;

    // Execute: decode op and compute data/target/jump for the issued slot.
    always_comb begin
        is_itype    = (op_from_rs >= OP_ADDI) && (op_from_rs <= OP_SRAI);
        op2         = is_itype ? imm_from_rs : v2_from_rs;
        shamt       = op2[4:0];
        pc_plus4    = pc_from_rs + 32'd4;
        pc_plus_imm = pc_from_rs + imm_from_rs;
        jalr_sum    = v1_from_rs + imm_from_rs;
        eq          = (v1_from_rs == v2_from_rs);
        lt_s        = ($signed(v1_from_rs) < $signed(v2_from_rs));
        lt_u        = (v1_from_rs < v2_from_rs);
        taken       = 1'b0;
        res_data    = 32'd0;
        res_tgt     = pc_plus4;
        res_jmp     = 1'b0;
        case (op_from_rs)
            OP_LUI:   res_data = imm_from_rs;
            OP_AUIPC: res_data = pc_plus_imm;
            OP_JAL: begin
                res_data = pc_plus4;
                res_tgt  = pc_plus_imm;
                res_jmp  = 1'b1;
            end
            OP_JALR: begin
                res_data = pc_plus4;
                res_tgt  = {jalr_sum[31:1], 1'b0};
                res_jmp  = 1'b1;
            end
            OP_BEQ:   taken = eq;
            OP_BNE:   taken = !eq;
            OP_BLT:   taken = lt_s;
            OP_BGE:   taken = !lt_s;
            OP_BLTU:  taken = lt_u;
            OP_BGEU:  taken = !lt_u;
            OP_ADDI,
            OP_ADD:   res_data = v1_from_rs + op2;
            OP_SUB:   res_data = v1_from_rs - op2;
            OP_SLTI,
            OP_SLT:   res_data = {31'd0, $signed(v1_from_rs) < $signed(op2)};
            OP_SLTIU,
            OP_SLTU:  res_data = {31'd0, v1_from_rs < op2};
            OP_XORI,
            OP_XOR:   res_data = v1_from_rs ^ op2;
            OP_ORI,
            OP_OR:    res_data = v1_from_rs | op2;
            OP_ANDI,
            OP_AND:   res_data = v1_from_rs & op2;
            OP_SLLI,
            OP_SLL:   res_data = v1_from_rs << shamt;
            OP_SRLI,
            OP_SRL:   res_data = v1_from_rs >> shamt;
            OP_SRAI,
            OP_SRA:   res_data = $unsigned($signed(v1_from_rs) >>> shamt);
            default:  res_data = 32'd0;
        endcase
        if (taken) begin
            res_tgt = pc_plus_imm;
            res_jmp = 1'b1;
        end
    end

    // Buffer control: push/pop/flush bookkeeping and sticky drop flag.
    always_comb begin
        pc_d    = pc_q;
        data_d  = data_q;
        tgt_d   = tgt_q;
        jmp_d   = jmp_q;
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        pop  = (count_q != 2'd0) && is_ready_from_rob
            && !is_exception_from_rob;
        push = !is_empty_from_rs && ((count_q != 2'd2) || pop)
            && !is_exception_from_rob;
        ovf_d = ovf_q | (!is_exception_from_rob && !is_empty_from_rs
            && (count_q == 2'd2) && !pop);
        if (is_exception_from_rob) begin
            count_d = 2'd0;
            head_d  = 1'b0;
            tail_d  = 1'b0;
        end else begin
            if (push) begin
                pc_d[tail_q]   = pc_from_rs;
                data_d[tail_q] = res_data;
                tgt_d[tail_q]  = res_tgt;
                jmp_d[tail_q]  = res_jmp;
                tail_d         = !tail_q;
            end
            if (pop) head_d = !head_q;
            count_d = count_q + {1'b0, push} - {1'b0, pop};
        end
    end

    // State registers; reset is asynchronous and wipes the buffer contents.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q    <= '{default: 32'd0};
            data_q  <= '{default: 32'd0};
            tgt_q   <= '{default: 32'd0};
            jmp_q   <= 2'd0;
            count_q <= 2'd0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            data_q  <= data_d;
            tgt_q   <= tgt_d;
            jmp_q   <= jmp_d;
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ovf_q   <= ovf_d;
        end
    end

    assign is_valid_to_rob  = (count_q != 2'd0);
    assign is_stall_to_rs   = (count_q == 2'd2);
    assign overflow_err     = ovf_q;
    assign pc_to_rob        = pc_q[head_q];
    assign data_to_rob      = data_q[head_q];
    assign target_pc_to_rob = tgt_q[head_q];
    assign is_jump_to_rob   = jmp_q[head_q];

endmodule

// File: tb/tb_alu_unit.sv
// tb_alu_unit: directed and randomized checks of alu_unit against
// a queue-based behavioural model of the result buffer.
module tb_alu_unit;

    logic        clk;
    logic        rst;
    logic        is_empty_from_rs;
    logic [5:0]  op_from_rs;
    logic [31:0] v1_from_rs;
    logic [31:0] v2_from_rs;
    logic [31:0] imm_from_rs;
    logic [31:0] pc_from_rs;
    logic        is_exception_from_rob;
    logic        is_ready_from_rob;
    logic        is_valid_to_rob;
    logic [31:0] pc_to_rob;
    logic [31:0] data_to_rob;
    logic [31:0] target_pc_to_rob;
    logic        is_jump_to_rob;
    logic        is_stall_to_rs;
    logic        overflow_err;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] d;
        logic [31:0] t;
        logic        j;
    } ent_t;

    ent_t q[$];
    bit   m_ovf;
    int   n_tests;
    int   n_fail;

    alu_unit dut (
        .clk                   (clk),
        .rst                   (rst),
        .is_empty_from_rs      (is_empty_from_rs),
        .op_from_rs            (op_from_rs),
        .v1_from_rs            (v1_from_rs),
        .v2_from_rs            (v2_from_rs),
        .imm_from_rs           (imm_from_rs),
        .pc_from_rs            (pc_from_rs),
        .is_exception_from_rob (is_exception_from_rob),
        .is_ready_from_rob     (is_ready_from_rob),
        .is_valid_to_rob       (is_valid_to_rob),
        .pc_to_rob             (pc_to_rob),
        .data_to_rob           (data_to_rob),
        .target_pc_to_rob      (target_pc_to_rob),
        .is_jump_to_rob        (is_jump_to_rob),
        .is_stall_to_rs        (is_stall_to_rs),
        .overflow_err          (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] a,
                       input logic [31:0] e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, a, e);
        end
    endtask

    // Reference semantics of one instruction.
    function automatic void ref_alu(input logic [5:0] op,
        input logic [31:0] v1, input logic [31:0] v2,
        input logic [31:0] imm, input logic [31:0] pc,
        output logic [31:0] d, output logic [31:0] t, output logic j);
        logic [31:0] b;
        int sh;
        bit tk;
        b  = (op >= 11 && op <= 19) ? imm : v2;
        sh = int'(b % 32);
        d  = 0;
        t  = pc + 4;
        j  = 0;
        tk = 0;
        case (op)
            1: d = imm;
            2: d = pc + imm;
            3: begin d = pc + 4; t = pc + imm; j = 1; end
            4: begin d = pc + 4; t = (v1 + imm) & 32'hFFFF_FFFE; j = 1; end
            5: tk = (v1 == v2);
            6: tk = (v1 != v2);
            7: tk = ($signed(v1) < $signed(v2));
            8: tk = ($signed(v1) >= $signed(v2));
            9: tk = (v1 < v2);
            10: tk = (v1 >= v2);
            11, 20: d = v1 + b;
            21: d = v1 - b;
            12, 23: d = ($signed(v1) < $signed(b)) ? 1 : 0;
            13, 24: d = (v1 < b) ? 1 : 0;
            14, 25: d = v1 ^ b;
            15, 28: d = v1 | b;
            16, 29: d = v1 & b;
            17, 22: d = v1 * (32'd1 << sh);
            18, 26: d = v1 / (33'd1 << sh);
            19, 27: d = (v1 / (33'd1 << sh))
                      | ((v1[31] && sh != 0) ? ~(32'hFFFF_FFFF >> sh) : 0);
            default: d = 0;
        endcase
        if (tk) begin t = pc + imm; j = 1; end
    endfunction

    task automatic check_all();
        chk("valid", {31'd0, is_valid_to_rob}, (q.size() != 0) ? 1 : 0);
        chk("stall", {31'd0, is_stall_to_rs}, (q.size() == 2) ? 1 : 0);
        chk("ovf", {31'd0, overflow_err}, {31'd0, m_ovf});
        if (q.size() != 0) begin
            chk("head_pc", pc_to_rob, q[0].pc);
            chk("head_data", data_to_rob, q[0].d);
            chk("head_tgt", target_pc_to_rob, q[0].t);
            chk("head_jmp", {31'd0, is_jump_to_rob}, {31'd0, q[0].j});
        end
    endtask

    // Drive one cycle, advance the model, then check at the next negedge.
    task automatic cyc(input bit iss, input logic [5:0] op,
        input logic [31:0] v1, input logic [31:0] v2,
        input logic [31:0] imm, input logic [31:0] pc,
        input bit rdy, input bit exc);
        ent_t e;
        bit pop;
        bit push;
        is_empty_from_rs      = !iss;
        op_from_rs            = op;
        v1_from_rs            = v1;
        v2_from_rs            = v2;
        imm_from_rs           = imm;
        pc_from_rs            = pc;
        is_ready_from_rob     = rdy;
        is_exception_from_rob = exc;
        if (exc) begin
            q.delete();
        end else begin
            pop  = (q.size() != 0) && rdy;
            push = iss && ((q.size() < 2) || pop);
            if (iss && !push) m_ovf = 1;
            if (pop) void'(q.pop_front());
            if (push) begin
                e.pc = pc;
                ref_alu(op, v1, v2, imm, pc, e.d, e.t, e.j);
                q.push_back(e);
            end
        end
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input bit rdy);
        cyc(0, 0, 0, 0, 0, 0, rdy, 0);
    endtask

    task automatic chk_zero_outputs(input string n);
        chk({n, "_valid"}, {31'd0, is_valid_to_rob}, 0);
        chk({n, "_stall"}, {31'd0, is_stall_to_rs}, 0);
        chk({n, "_ovf"}, {31'd0, overflow_err}, 0);
        chk({n, "_pc"}, pc_to_rob, 0);
        chk({n, "_data"}, data_to_rob, 0);
        chk({n, "_tgt"}, target_pc_to_rob, 0);
        chk({n, "_jmp"}, {31'd0, is_jump_to_rob}, 0);
    endtask

    initial begin
        logic [5:0]  rop;
        logic [31:0] rv1;
        logic [31:0] rv2;
        n_tests = 0;
        n_fail  = 0;
        m_ovf   = 0;
        rst                   = 1;
        is_empty_from_rs      = 1;
        op_from_rs            = 0;
        v1_from_rs            = 0;
        v2_from_rs            = 0;
        imm_from_rs           = 0;
        pc_from_rs            = 0;
        is_exception_from_rob = 0;
        is_ready_from_rob     = 0;
        @(negedge clk);
        @(negedge clk);
        chk_zero_outputs("reset");
        rst = 0;

        cyc(1, 20, 32'hFFFF_FFFF, 2, 0, 32'h100, 1, 0);
        chk("add_valid", {31'd0, is_valid_to_rob}, 1);
        chk("add_pc", pc_to_rob, 32'h100);
        chk("add_data", data_to_rob, 32'h1);
        chk("add_tgt", target_pc_to_rob, 32'h104);
        chk("add_jmp", {31'd0, is_jump_to_rob}, 0);

        cyc(1, 19, 32'h8000_0000, 0, 32'h24, 32'h110, 1, 0);
        chk("srai_data", data_to_rob, 32'hF800_0000);
        cyc(1, 24, 1, 32'hFFFF_FFFF, 0, 32'h114, 1, 0);
        chk("sltu_data", data_to_rob, 1);
        cyc(1, 23, 1, 32'hFFFF_FFFF, 0, 32'h118, 1, 0);
        chk("slt_data", data_to_rob, 0);

        cyc(1, 4, 32'h1003, 0, 4, 32'h200, 1, 0);
        chk("jalr_data", data_to_rob, 32'h204);
        chk("jalr_tgt", target_pc_to_rob, 32'h1006);
        chk("jalr_jmp", {31'd0, is_jump_to_rob}, 1);
        cyc(1, 6, 5, 5, 32'h40, 32'h300, 1, 0);
        chk("bne_tgt", target_pc_to_rob, 32'h304);
        chk("bne_jmp", {31'd0, is_jump_to_rob}, 0);
        chk("bne_data", data_to_rob, 0);
        idle(1);

        cyc(1, 11, 1, 0, 1, 32'h400, 0, 0);
        cyc(1, 11, 2, 0, 2, 32'h404, 0, 0);
        chk("full_stall", {31'd0, is_stall_to_rs}, 1);
        cyc(1, 11, 3, 0, 3, 32'h408, 0, 0);
        chk("drop_ovf", {31'd0, overflow_err}, 1);
        chk("drop_head", pc_to_rob, 32'h400);
        idle(1);
        chk("drain1_pc", pc_to_rob, 32'h404);
        chk("drain1_data", data_to_rob, 4);
        idle(1);
        chk("drain2_valid", {31'd0, is_valid_to_rob}, 0);

        cyc(1, 20, 1, 1, 0, 32'h500, 0, 0);
        cyc(1, 20, 2, 2, 0, 32'h504, 0, 0);
        cyc(1, 20, 3, 3, 0, 32'h508, 1, 1);
        chk("flush_valid", {31'd0, is_valid_to_rob}, 0);
        chk("flush_stall", {31'd0, is_stall_to_rs}, 0);
        chk("flush_ovf", {31'd0, overflow_err}, 1);
        idle(1);

        for (int i = 0; i < 3000; i++) begin
            rop = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(0, 63))
                                              : 6'($urandom_range(0, 29));
            rv1 = $urandom;
            rv2 = ($urandom_range(0, 3) == 0) ? rv1 : $urandom;
            cyc($urandom_range(0, 9) < 7, rop, rv1, rv2, $urandom,
                $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 39) == 0);
            if (i == 1500) begin
                #2 rst = 1;
                #1 chk_zero_outputs("midrst");
                q.delete();
                m_ovf = 0;
                @(negedge clk);
                check_all();
                rst = 0;
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
